// File: rtl/num_conditioner.sv
// Synchronise, debounce and edge-detect a raw level input; emits one num_o pulse per accepted edge.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from first sample to pulse; no backpressure, num_o is fire-and-forget.
module num_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_MODE       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_i,
   input  logic       en_i,
   output logic       num_o,
   output logic       level_o,
   output logic       busy_o,
   output logic [7:0] reject_cnt_o
);

   localparam int SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYCLES - 1);
   localparam bit PULSE_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
   localparam bit PULSE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

   typedef enum logic [1:0] {
      IDLE_LOW,
      CHECK_HIGH,
      IDLE_HIGH,
      CHECK_LOW
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   state_t                 state, state_nxt;
   logic [SW-1:0]          stab, stab_nxt;
   logic                   level_nxt;
   logic                   num_nxt;
   logic [7:0]             rej_nxt;
   logic [7:0]             rej_inc;
   logic                   rise_acc, fall_acc;

   assign sync    = sync_q[SYNC_STAGES-1];
   assign rej_inc = (reject_cnt_o == 8'hFF) ? reject_cnt_o : reject_cnt_o + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   always_comb begin
      state_nxt = state;
      stab_nxt  = stab;
      level_nxt = level_o;
      rej_nxt   = reject_cnt_o;
      rise_acc  = 1'b0;
      fall_acc  = 1'b0;
      case (state)
         IDLE_LOW: begin
            if (sync) begin
               state_nxt = CHECK_HIGH;
               stab_nxt  = '0;
            end
         end
         CHECK_HIGH: begin
            if (!sync) begin
               state_nxt = IDLE_LOW;
               rej_nxt   = rej_inc;
            end else if (stab == STAB_MAX) begin
               state_nxt = IDLE_HIGH;
               level_nxt = 1'b1;
               rise_acc  = 1'b1;
            end else begin
               stab_nxt = stab + 1'b1;
            end
         end
         IDLE_HIGH: begin
            if (!sync) begin
               state_nxt = CHECK_LOW;
               stab_nxt  = '0;
            end
         end
         CHECK_LOW: begin
            if (sync) begin
               state_nxt = IDLE_HIGH;
               rej_nxt   = rej_inc;
            end else if (stab == STAB_MAX) begin
               state_nxt = IDLE_LOW;
               level_nxt = 1'b0;
               fall_acc  = 1'b1;
            end else begin
               stab_nxt = stab + 1'b1;
            end
         end
         default: state_nxt = IDLE_LOW;
      endcase
      // en_i only gates the pulse; an edge accepted while disabled is dropped
      num_nxt = en_i & ((PULSE_RISE & rise_acc) | (PULSE_FALL & fall_acc));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE_LOW;
         stab         <= '0;
         num_o        <= 1'b0;
         level_o      <= 1'b0;
         busy_o       <= 1'b0;
         reject_cnt_o <= 8'd0;
      end else begin
         state        <= state_nxt;
         stab         <= stab_nxt;
         num_o        <= num_nxt;
         level_o      <= level_nxt;
         busy_o       <= (state_nxt == CHECK_HIGH) || (state_nxt == CHECK_LOW);
         reject_cnt_o <= rej_nxt;
      end
   end

endmodule

// File: doc/num_conditioner.md
# num_conditioner

Input conditioning stage directly upstream of the event counter: takes a raw, asynchronous, possibly bouncing level input, synchronises and debounces it, and emits a clean single-cycle pulse per accepted edge on `num_o`, which drives the counter's `num_i`. It also reports the debounced level, a busy flag while an edge is being qualified, and a saturating count of rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count (legal values ≥ 2).
- `DEBOUNCE_CYCLES`, default 4: a new level must hold for this many cycles after qualification starts (legal values ≥ 1).
- `EDGE_MODE`, default 0: pulse on 0 = rising, 1 = falling, 2 = both accepted edges.

- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `raw_i`  in  1: asynchronous raw level input.
- `en_i`  in  1: pulse enable; 0 suppresses `num_o` only.
- `num_o`  out  1: one-cycle pulse per accepted edge matching `EDGE_MODE`.
- `level_o`  out  1: debounced level.
- `busy_o`  out  1: high while in a CHECK state.
- `reject_cnt_o`  out  8: count of rejected glitches, saturating at 255.

## Operation
- `raw_i` enters a `SYNC_STAGES`-deep flop chain. The last stage, `sync`, is the only value the FSM sees.
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. A stability counter `stab` is sized to hold `DEBOUNCE_CYCLES-1`.
- IDLE_LOW:
  - `sync`=1 → CHECK_HIGH, `stab`←0.
  - Otherwise stay.
- CHECK_HIGH:
  - `sync`=0 → IDLE_LOW, `reject_cnt`+1 (saturating).
  - `sync`=1 and `stab`==`DEBOUNCE_CYCLES-1` → IDLE_HIGH, `level_o`←1, rising edge accepted.
  - Otherwise `stab`+1.
- IDLE_HIGH and CHECK_LOW mirror the above with the polarity inverted. Acceptance sets `level_o`←0 and accepts a falling edge.
- On an accepted edge, `num_o`←1 for exactly one cycle if `en_i`=1 in the accepting cycle and the edge matches `EDGE_MODE`; otherwise `num_o`←0. `level_o` and the FSM update regardless of `en_i`.
- `busy_o` is high in CHECK_HIGH and CHECK_LOW.
- `reject_cnt_o` holds at 255 once reached. It is cleared only by `rst`.
- All outputs are registered; there are no combinational paths from input to output.

## Timing
- Reset:
  - Synchroniser flops 0, state IDLE_LOW, `stab` 0.
  - `num_o`=0, `level_o`=0, `busy_o`=0, `reject_cnt_o`=0.
  - Outputs take these values in the cycle after the reset edge.
- Latency: `raw_i` first sampled 1 at edge E0 and held → `num_o` high for the cycle following edge E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES` (defaults: E0+6). `level_o` rises at the same edge.
- Acceptance requires `sync` to equal the new level at `DEBOUNCE_CYCLES`+1 consecutive edges.
- A glitch shorter than that leaves `level_o` unchanged, produces no pulse, and increments `reject_cnt_o` by 1 at the edge where `sync` reverts.
- Minimum spacing between `num_o` pulses:
  - `EDGE_MODE` 0 or 1: 2·(`DEBOUNCE_CYCLES`+1) cycles.
  - `EDGE_MODE` 2: `DEBOUNCE_CYCLES`+1 cycles.
  - `num_o` is never high on two consecutive cycles.
- `rst` asserted mid-CHECK: return to IDLE_LOW, no pulse, no reject increment. `rst` has priority over all other events in the same cycle.
- `raw_i` held high through reset: after release the input is re-qualified as a new rising edge. Expect a pulse at release+`SYNC_STAGES`+`DEBOUNCE_CYCLES` if `en_i`=1.
- `en_i` is sampled only in the accepting cycle. An edge accepted while `en_i`=0 is lost; it is not deferred.

## Test plan
- Reset, then a clean rising step on `raw_i` at edge E0 with `en_i`=1 (defaults) → `num_o` is a single 1-cycle pulse after E0+6; `level_o`=1 from the same edge; `busy_o` high for 4 cycles beforehand; `reject_cnt_o`=0.
- Three 3-cycle high glitches on a low input → no `num_o` pulse; `level_o` stays 0; `reject_cnt_o`=3.
- `EDGE_MODE`=2; raw square wave with 20-cycle half period, 5 full periods → 10 pulses on `num_o`, each 1 cycle wide, each 6 cycles after the corresponding raw edge.
- 300 glitches → `reject_cnt_o` saturates at 255 and stays there; a subsequent `rst` returns it to 0.
- `rst` asserted 2 cycles into CHECK_HIGH → state IDLE_LOW, no pulse; with `raw_i` still high, one pulse 6 cycles after `rst` deasserts.
- `en_i`=0 during an accepted rising edge → `level_o` rises but `num_o` stays 0; with `en_i`=1 at the next edge, pulses resume.
